// File: rtl/fft_frame_scheduler.sv
// Ping-pong frame buffer that streams one whole frame per FFT run and waits for fft_done.
// Define FFT_SCHED_HANN_EN to apply a Q1.15 Hann window to streamed samples (one extra stage).
module fft_frame_scheduler #(
  parameter int W            = 16,
  parameter int NSamples     = 256,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [W-1:0] sample_data,
  input  logic         sample_valid,
  output logic [W-1:0] fft_in_data,
  output logic         fft_in_valid,
  input  logic         fft_in_ready,
  output logic         fft_in_first,
  output logic         fft_in_last,
  input  logic         fft_done,
  output logic         busy,
  output logic [15:0]  frames_sent,
  output logic         overrun
);
  localparam int IW = $clog2(NSamples);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSamples - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_DONE} state_t;
  state_t r_state, w_next;

  logic [W-1:0]  r_mem [2*NSamples];
  logic [1:0]    r_bank_full, w_bank_full_nxt;
  logic          r_wr_bank, r_rd_bank, r_drop, r_overrun;
  logic [IW-1:0] r_wr_idx, r_rd_idx;
  logic          r_issued_all;
  logic [TW-1:0] r_timer;
  logic [15:0]   r_frames;
  logic [W-1:0]  r_out_data;
  logic          r_out_valid, r_out_first, r_out_last;

  logic w_wr_fire, w_wr_last, w_accept, w_release, w_adv, w_issue, w_other_free;
  logic         w_pipe_valid, w_pipe_first, w_pipe_last;
  logic [W-1:0] w_pipe_data;

  assign w_wr_fire    = sample_valid & enable & ~r_drop;
  assign w_wr_last    = w_wr_fire & (r_wr_idx == LAST_IDX);
  assign w_accept     = r_out_valid & fft_in_ready;
  assign w_release    = w_accept & r_out_last;
  assign w_adv        = ~r_out_valid | fft_in_ready;
  assign w_issue      = (r_state == S_STREAM) & ~r_issued_all & w_adv;
  // A bank released this cycle counts as free, so a simultaneous fill never drops.
  assign w_other_free = ~r_bank_full[~r_wr_bank] | (w_release & (r_rd_bank != r_wr_bank));

  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_release) w_bank_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_last) w_bank_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[{r_wr_bank, r_wr_idx}] <= sample_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bank_full <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_drop      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_bank_full <= w_bank_full_nxt;
      if (r_drop) begin
        if (sample_valid && enable) r_overrun <= 1'b1;
        if (w_release) begin
          r_drop    <= 1'b0;
          r_wr_bank <= r_rd_bank;
          r_wr_idx  <= '0;
        end
      end else if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_idx <= '0;
          if (w_other_free) r_wr_bank <= ~r_wr_bank;
          else              r_drop    <= 1'b1;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (enable && r_bank_full[r_rd_bank]) w_next = S_STREAM;
      S_STREAM:    if (w_release) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (fft_done || r_timer == '0) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_idx     <= '0;
      r_issued_all <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_frames     <= '0;
      r_timer      <= '0;
    end else begin
      if (r_state != S_STREAM) begin
        r_rd_idx     <= '0;
        r_issued_all <= 1'b0;
      end else if (w_issue) begin
        r_rd_idx <= r_rd_idx + 1'b1;
        if (r_rd_idx == LAST_IDX) r_issued_all <= 1'b1;
      end
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
        r_frames  <= r_frames + 16'd1;
        r_timer   <= TW'(DONE_TIMEOUT - 1);
      end else if (r_state == S_WAIT_DONE && r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

`ifdef FFT_SCHED_HANN_EN
  function automatic logic [15:0] f_hann(input int n);
    real c;
    c = (0.5 - 0.5 * $cos(6.283185307179586 * real'(n) / real'(NSamples))) * 32768.0;
    if (c > 32767.0) c = 32767.0;
    return 16'($rtoi(c + 0.5));
  endfunction

  logic [15:0] w_rom [NSamples];
  for (genvar g = 0; g < NSamples; g++) begin : g_rom
    assign w_rom[g] = f_hann(g);
  end

  logic                r_s1_valid, r_s1_first, r_s1_last;
  logic [W-1:0]        r_s1_data;
  logic [15:0]         r_s1_coef;
  logic signed [W+15:0] w_prod, w_shift;
  logic [W-1:0]        w_win;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_data  <= '0;
      r_s1_coef  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_issue;
      r_s1_first <= w_issue & (r_rd_idx == '0);
      r_s1_last  <= w_issue & (r_rd_idx == LAST_IDX);
      r_s1_data  <= r_mem[{r_rd_bank, r_rd_idx}];
      r_s1_coef  <= w_rom[r_rd_idx];
    end
  end

  assign w_prod  = $signed(r_s1_data) * $signed(r_s1_coef);
  assign w_shift = w_prod >>> 15;

  always_comb begin
    w_win = w_shift[W-1:0];
    if (!(&w_shift[W+15:W-1]) && (|w_shift[W+15:W-1]))
      w_win = w_shift[W+15] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  assign w_pipe_valid = r_s1_valid;
  assign w_pipe_first = r_s1_first;
  assign w_pipe_last  = r_s1_last;
  assign w_pipe_data  = w_win;
`else
  assign w_pipe_valid = w_issue;
  assign w_pipe_first = r_rd_idx == '0;
  assign w_pipe_last  = r_rd_idx == LAST_IDX;
  assign w_pipe_data  = r_mem[{r_rd_bank, r_rd_idx}];
`endif

  // Whole output path advances together, so a stall freezes every stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_adv) begin
      r_out_valid <= w_pipe_valid;
      r_out_first <= w_pipe_valid & w_pipe_first;
      r_out_last  <= w_pipe_valid & w_pipe_last;
      if (w_pipe_valid) r_out_data <= w_pipe_data;
    end
  end

  assign fft_in_data  = r_out_data;
  assign fft_in_valid = r_out_valid;
  assign fft_in_first = r_out_first;
  assign fft_in_last  = r_out_last;
  assign busy         = r_state != S_IDLE;
  assign frames_sent  = r_frames;
  assign overrun      = r_overrun;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler (NSamples=8, DONE_TIMEOUT=64, default build).
module tb_fft_frame_scheduler;
  localparam int W = 16;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic [W-1:0] sample_data;
  logic         sample_valid;
  logic [W-1:0] fft_in_data;
  logic         fft_in_valid;
  logic         fft_in_ready;
  logic         fft_in_first;
  logic         fft_in_last;
  logic         fft_done;
  logic         busy;
  logic [15:0]  frames_sent;
  logic         overrun;

  fft_frame_scheduler #(.W(W), .NSamples(N), .DONE_TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .fft_in_data(fft_in_data), .fft_in_valid(fft_in_valid), .fft_in_ready(fft_in_ready),
    .fft_in_first(fft_in_first), .fft_in_last(fft_in_last), .fft_done(fft_done),
    .busy(busy), .frames_sent(frames_sent), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         f;
    logic         l;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: accepted beats are popped and compared; stalled beats must hold.
  beat_t r_held_beat;
  logic  r_held = 1'b0;
  always @(negedge clk) begin
    beat_t b;
    beat_t cur;
    cur = '{d: fft_in_data, f: fft_in_first, l: fft_in_last};
    if (reset_n && fft_in_valid) begin
      if (r_held) begin
        n_checks++;
        if (cur === r_held_beat) n_pass++;
        else $display("FAIL stall_hold: got %h expected %h", cur, r_held_beat);
      end
      if (fft_in_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_beat: got %h expected none", cur);
        end else begin
          b = q.pop_front();
          if (cur === b) n_pass++;
          else $display("FAIL beat: got %h expected %h", cur, b);
        end
      end
    end
    r_held      <= reset_n && fft_in_valid && !fft_in_ready;
    r_held_beat <= cur;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v);
    sample_data  = v;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] base, input bit expect_it);
    for (int i = 0; i < N; i++) begin
      if (expect_it) q.push_back('{d: base + W'(i), f: (i == 0), l: (i == N - 1)});
      send(base + W'(i));
    end
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    tick(1);
    fft_done = 1'b0;
  endtask

  task automatic wait_q(input int target, input string name);
    int cyc;
    cyc = 0;
    while ((q.size() != target || fft_in_valid) && cyc < 200) begin
      tick(1);
      cyc++;
    end
    if (cyc >= 200) begin
      n_checks++;
      $display("FAIL %s_timeout: got queue %0d expected %0d", name, q.size(), target);
    end
  endtask

  initial begin
    int pattern [4];
    int cyc;
    pattern = '{1, 0, 0, 1};
    reset_n = 1'b0; enable = 1'b0; sample_data = '0; sample_valid = 1'b0;
    fft_in_ready = 1'b0; fft_done = 1'b0;
    tick(3);
    check("rst_valid", fft_in_valid, 0);
    check("rst_data", fft_in_data, 0);
    check("rst_first_last", {fft_in_first, fft_in_last}, 0);
    check("rst_busy", busy, 0);
    check("rst_frames", frames_sent, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    tick(1);

    // Single frame 1..8
    enable = 1'b1; fft_in_ready = 1'b1;
    send_frame(16'd1, 1);
    wait_q(0, "t1_drain");
    check("t1_frames", frames_sent, 1);
    check("t1_busy_wait_done", busy, 1);
    pulse_done();
    check("t1_busy_idle", busy, 0);

    // Two frames back-to-back, second held until fft_done
    send_frame(16'd1, 1);
    send_frame(16'd9, 1);
    wait_q(8, "t2_first");
    tick(20);
    check("t2_held_queue", q.size(), 8);
    check("t2_frames_held", frames_sent, 2);
    check("t2_busy_wait", busy, 1);
    pulse_done();
    tick(2);
    pulse_done();
    wait_q(0, "t2_second");
    check("t2_frames", frames_sent, 3);
    check("t2_done_in_stream_ignored", busy, 1);
    pulse_done();
    check("t2_idle", busy, 0);

    // Samples with enable low are ignored; ready pattern 1,0,0,1; fft_done timeout
    enable = 1'b0;
    send(16'hdead);
    send(16'hbeef);
    enable = 1'b1;
    fft_in_ready = 1'b0;
    send_frame(16'h0030, 1);
    cyc = 0;
    while ((q.size() != 0 || fft_in_valid) && cyc < 200) begin
      fft_in_ready = pattern[cyc % 4][0];
      tick(1);
      cyc++;
    end
    if (cyc >= 200) check("t3_drain_timeout", q.size(), 0);
    fft_in_ready = 1'b1;
    check("t3_frames", frames_sent, 4);
    cyc = 0;
    while (busy && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("t3_timeout_window", (cyc >= 60 && cyc <= 68), 1);

    // Overrun: both banks full while reader stalled
    fft_in_ready = 1'b0;
    send_frame(16'h0040, 1);
    send_frame(16'h0048, 1);
    check("t4_no_overrun_yet", overrun, 0);
    for (int i = 0; i < 4; i++) send(16'h00ee);
    check("t4_overrun", overrun, 1);
    fft_in_ready = 1'b1;
    wait_q(8, "t4_a");
    check("t4_frames_a", frames_sent, 5);
    send_frame(16'h0060, 1);
    check("t4_queue_bc", q.size(), 16);
    check("t4_busy_wait", busy, 1);
    pulse_done();
    wait_q(8, "t4_b");
    pulse_done();
    wait_q(0, "t4_c");
    check("t4_frames", frames_sent, 7);
    check("t4_overrun_sticky", overrun, 1);
    pulse_done();

    // Reset mid-stream with a partial frame pending
    fft_in_ready = 1'b0;
    send_frame(16'h0050, 0);
    tick(3);
    check("t5_stalled_valid", fft_in_valid, 1);
    for (int i = 0; i < 5; i++) send(16'h0058 + W'(i));
    reset_n = 1'b0;
    #2;
    check("t5_valid_async", fft_in_valid, 0);
    check("t5_data", fft_in_data, 0);
    check("t5_busy", busy, 0);
    check("t5_frames", frames_sent, 0);
    check("t5_overrun", overrun, 0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    fft_in_ready = 1'b1;
    send_frame(16'h0070, 1);
    wait_q(0, "t5_drain");
    check("t5_frames_after", frames_sent, 1);
    pulse_done();
    tick(4);
    check("scoreboard_empty", q.size(), 0);
    check("end_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Sits between mic_load (sample stream, already in the FFT clock domain) and fft_pitch_detect's FFT input port.
- Collects audio samples into a ping-pong frame buffer of 2×NSamples words.
- Schedules whole frames into the FFT: streams one frame per FFT run, then waits for the FFT's completion pulse before issuing the next.
- Handles overrun when the FFT cannot keep up, and reports status.

Parameters:
- W, 16, sample width in bits.
- NSamples, 256, frame length; power of two, ≥4.
- DONE_TIMEOUT, 4096, clk cycles to wait for fft_done before forcing return to IDLE.

Ports:
- clk  input  1  FFT-domain clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  when low, incoming samples are ignored and no new frame is launched. A frame already in STREAM completes.
- sample_data  input  W  audio sample.
- sample_valid  input  1  one-cycle strobe per sample.
- fft_in_data  output  W  frame sample to FFT.
- fft_in_valid  output  1  fft_in_data valid.
- fft_in_ready  input  1  FFT accepts the beat when valid&&ready.
- fft_in_first  output  1  high on beat 0 of a frame.
- fft_in_last  output  1  high on beat NSamples-1.
- fft_done  input  1  one-cycle pulse: FFT finished current frame.
- busy  output  1  high while the read FSM is not in IDLE.
- frames_sent  output  16  count of frames fully streamed; wraps at 2^16.
- overrun  output  1  sticky; set on the first dropped sample, cleared only by reset.

Behaviour:
- Reset values: all outputs 0; bank_full=2'b00; wr_bank=0; rd_bank=0; wr_idx=0; FSM=IDLE.
- Write side:
  - On sample_valid&&enable&&!drop: mem[wr_bank][wr_idx]<=sample_data; wr_idx++.
  - When wr_idx==NSamples-1 is written: bank_full[wr_bank]<=1; wr_idx<=0.
    - If bank_full[~wr_bank]==0, or that bank is released in the same cycle: wr_bank<=~wr_bank.
    - Otherwise enter drop.
  - drop = both banks full. While in drop, samples are discarded and overrun<=1.
  - Exit drop when the reader releases a bank: wr_bank<=released bank, wr_idx=0.
  - Release and fill in the same cycle: the release is applied first, so no sample is dropped.
- Read FSM:
  - IDLE: if enable && bank_full[rd_bank] -> STREAM; rd_idx=0.
  - STREAM: memory read is registered. fft_in_valid asserts within 2 cycles of entering STREAM.
    - While valid&&!ready, fft_in_data/first/last are held stable.
    - With ready held high, output is one beat per cycle with no bubbles after the first beat.
    - On acceptance of the last beat: bank_full[rd_bank]<=0 (release); rd_bank<=~rd_bank; frames_sent++; fft_in_valid deasserts next cycle; -> WAIT_DONE.
  - WAIT_DONE: on fft_done -> IDLE.
    - A timeout counter reaching DONE_TIMEOUT also -> IDLE.
    - An fft_done pulse received in IDLE or STREAM is ignored.
- rd_bank strictly alternates, so frames are always delivered oldest-first.
- enable falling mid-frame: the write index is held (partial frame retained). The current STREAM completes.
- reset_n asserted mid-operation: everything returns to reset values immediately; partial frames are discarded; fft_in_valid drops asynchronously.
- busy = (state != IDLE).

Optional Feature:
- Macro FFT_SCHED_HANN_EN.
- When defined:
  - Each streamed sample is multiplied by a Q1.15 Hann coefficient from an NSamples-entry ROM indexed by rd_idx.
  - The result is a signed W×16 product, arithmetic-shifted right by 15, saturated to W bits.
  - Adds exactly one pipeline stage. Valid/ready semantics are unchanged; the hold-while-stalled rule covers the extra stage.
- When undefined: samples pass unmodified and there is no ROM.

Test Plan (NSamples=8, W=16):
- Reset, then 8 samples 1..8 with ready=1 -> one frame 1..8 streamed; first on 1, last on 8; frames_sent=1; busy high until fft_done.
- 16 samples back-to-back, no fft_done issued -> frame 1 streamed, FSM stuck in WAIT_DONE. Pulse fft_done -> frame 2 (9..16) streamed; frames_sent=2.
- ready toggled 1,0,0,1 during STREAM -> no beat lost or duplicated; data stable across stalled cycles.
- 24 samples with no fft_done, then 4 more -> overrun=1. Samples 17..28 dropped. Frames 1..8 and then 9..16 are delivered in order. After the frame-1 release, the write side refills bank 0.
- Assert reset_n low after 5 samples -> all outputs 0. Next 8 samples form a clean frame starting at index 0.
- FFT_SCHED_HANN_EN defined, constant input 0x4000 -> beat 0 outputs 0, the middle beat is ≈0x4000, and the output shape is symmetric.
